alu_dispatch: RTL and testbench

ALU_DISPATCH -- requirements
Module: alu_dispatch

---
 rtl/alu_dispatch.sv | 128 ++++++++++++
 tb/tb_alu_dispatch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_dispatch.sv
// Dispatches one request at a time to an arithmetic or logic unit, waits for
// that unit's done (bounded by TIMEOUT cycles) and holds the response until accepted.
module alu_dispatch #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic       au_valid,
  output logic [2:0] au_op,
  output logic [7:0] au_a,
  output logic [7:0] au_b,
  input  logic       au_done,
  input  logic [7:0] au_result,
  input  logic [3:0] au_nzvc,
  output logic       lu_valid,
  output logic [2:0] lu_op,
  output logic [7:0] lu_a,
  output logic [7:0] lu_b,
  input  logic       lu_done,
  input  logic [7:0] lu_result,
  input  logic [3:0] lu_nzvc,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic [3:0] rsp_nzvc,
  output logic       rsp_unit,
  output logic       rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic [3:0] op_q;
  logic [7:0] a_q, b_q;
  logic [7:0] cnt_q;
  logic [7:0] res_q;
  logic [3:0] nzvc_q;
  logic       unit_q, err_q;
  logic       sel_unit, sel_done, timeout_hit, busy;

  assign sel_unit    = op_q[3];
  assign sel_done    = sel_unit ? lu_done : au_done;
  assign timeout_hit = (cnt_q == CNT_LAST);
  assign busy        = (state == S_ISSUE) || (state == S_WAIT);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (req_valid) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (sel_done || timeout_hit) state_nx = S_RESP;
      S_RESP:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Done takes priority over timeout; response fields only change on WAIT exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
      nzvc_q <= '0;
      unit_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q <= req_op;
            a_q  <= req_a;
            b_q  <= req_b;
          end
        end
        S_ISSUE: cnt_q <= '0;
        S_WAIT: begin
          if (sel_done) begin
            res_q  <= sel_unit ? lu_result : au_result;
            nzvc_q <= sel_unit ? lu_nzvc : au_nzvc;
            unit_q <= sel_unit;
            err_q  <= 1'b0;
          end else if (timeout_hit) begin
            res_q  <= '0;
            nzvc_q <= '0;
            unit_q <= sel_unit;
            err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == S_IDLE);
  assign rsp_valid  = (state == S_RESP);
  assign rsp_result = res_q;
  assign rsp_nzvc   = nzvc_q;
  assign rsp_unit   = unit_q;
  assign rsp_err    = err_q;

  // Only the selected unit ever sees non-zero operands, and only while busy.
  assign au_valid = (state == S_ISSUE) && !sel_unit;
  assign au_op    = (busy && !sel_unit) ? op_q[2:0] : 3'd0;
  assign au_a     = (busy && !sel_unit) ? a_q : 8'd0;
  assign au_b     = (busy && !sel_unit) ? b_q : 8'd0;

  assign lu_valid = (state == S_ISSUE) && sel_unit;
  assign lu_op    = (busy && sel_unit) ? op_q[2:0] : 3'd0;
  assign lu_a     = (busy && sel_unit) ? a_q : 8'd0;
  assign lu_b     = (busy && sel_unit) ? b_q : 8'd0;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed self-checking bench for alu_dispatch with hand-computed expectations.
module tb_alu_dispatch;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_op;
  logic [7:0] req_a, req_b;
  logic       au_valid;
  logic [2:0] au_op;
  logic [7:0] au_a, au_b;
  logic       au_done;
  logic [7:0] au_result;
  logic [3:0] au_nzvc;
  logic       lu_valid;
  logic [2:0] lu_op;
  logic [7:0] lu_a, lu_b;
  logic       lu_done;
  logic [7:0] lu_result;
  logic [3:0] lu_nzvc;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic [3:0] rsp_nzvc;
  logic       rsp_unit;
  logic       rsp_err;

  int checks = 0;
  int errors = 0;

  alu_dispatch #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .au_valid(au_valid), .au_op(au_op), .au_a(au_a), .au_b(au_b),
    .au_done(au_done), .au_result(au_result), .au_nzvc(au_nzvc),
    .lu_valid(lu_valid), .lu_op(lu_op), .lu_a(lu_a), .lu_b(lu_b),
    .lu_done(lu_done), .lu_result(lu_result), .lu_nzvc(lu_nzvc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_nzvc(rsp_nzvc), .rsp_unit(rsp_unit), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Called right after a negedge; returns at the negedge following the accept edge (ISSUE).
  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic finishResp(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput({tag, "_idle"}, {31'd0, rsp_valid, req_ready}, 32'b01);
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    au_done = 1'b0; au_result = '0; au_nzvc = '0;
    lu_done = 1'b0; lu_result = '0; lu_nzvc = '0;
    rsp_ready = 1'b0;
    #3;
    checkOutput("reset_outs", {req_ready, rsp_valid, au_valid, lu_valid, rsp_result, rsp_nzvc, rsp_err},
                {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Arithmetic op, unit latency 2, issued on the first edge after reset release
    applyStimulus(4'b0001, 8'h7F, 8'h01);
    checkOutput("arith_issue", {au_valid, au_op, au_a, au_b}, {1'b1, 3'd1, 8'h7F, 8'h01});
    checkOutput("arith_lu_zero", {lu_valid, lu_op, lu_a, lu_b}, 32'd0);
    checkOutput("arith_busy", {req_ready, rsp_valid}, 32'd0);
    @(negedge clk);
    checkOutput("arith_wait1", {au_valid, au_a, au_b}, {1'b0, 8'h7F, 8'h01});
    @(negedge clk);
    au_done = 1'b1; au_result = 8'h80; au_nzvc = 4'b1010;
    checkOutput("arith_wait2_norsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    au_done = 1'b0;
    checkOutput("arith_rsp", {rsp_valid, rsp_result, rsp_nzvc, rsp_unit, rsp_err},
                {1'b1, 8'h80, 4'hA, 1'b0, 1'b0});
    checkOutput("arith_rsp_au_zero", {au_valid, au_op, au_a, au_b}, 32'd0);
    finishResp("arith");
    checkOutput("arith_retain", {rsp_result, rsp_nzvc}, {8'h80, 4'hA});

    // Logic op, unit latency 1
    applyStimulus(4'b1010, 8'hF0, 8'h0F);
    checkOutput("logic_issue", {lu_valid, lu_op, lu_a, lu_b}, {1'b1, 3'd2, 8'hF0, 8'h0F});
    checkOutput("logic_au_zero_issue", {au_valid, au_op, au_a, au_b}, 32'd0);
    @(negedge clk);
    lu_done = 1'b1; lu_result = 8'h00; lu_nzvc = 4'b0100;
    checkOutput("logic_wait", {lu_valid, lu_a, au_valid, au_a}, {1'b0, 8'hF0, 1'b0, 8'h00});
    @(negedge clk);
    lu_done = 1'b0;
    checkOutput("logic_rsp", {rsp_valid, rsp_result, rsp_nzvc, rsp_unit, rsp_err},
                {1'b1, 8'h00, 4'h4, 1'b1, 1'b0});
    finishResp("logic");

    // Timeout: no done for 15 WAIT cycles
    applyStimulus(4'b0011, 8'h12, 8'h34);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad++;
    end
    checkOutput("tmo_no_early_rsp", bad, 0);
    @(negedge clk);
    checkOutput("tmo_rsp", {rsp_valid, rsp_result, rsp_nzvc, rsp_unit, rsp_err},
                {1'b1, 8'h00, 4'h0, 1'b0, 1'b1});
    finishResp("tmo");

    // Done on the 15th WAIT cycle beats the timeout
    applyStimulus(4'b0011, 8'h12, 8'h34);
    for (int i = 0; i < 14; i++) @(negedge clk);
    checkOutput("tmo_edge_retain_err", {rsp_valid, rsp_err}, 32'b01);
    @(negedge clk);
    au_done = 1'b1; au_result = 8'h5A; au_nzvc = 4'b0011;
    checkOutput("tmo_edge_still_wait", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    au_done = 1'b0;
    checkOutput("tmo_edge_rsp", {rsp_valid, rsp_result, rsp_nzvc, rsp_err},
                {1'b1, 8'h5A, 4'h3, 1'b0});
    finishResp("tmo_edge");

    // ISSUE-cycle done and wrong-unit done ignored, then backpressure
    applyStimulus(4'b1001, 8'h0A, 8'h0B);
    lu_done = 1'b1; lu_result = 8'h55; lu_nzvc = 4'hF;
    @(negedge clk);
    lu_done = 1'b0;
    au_done = 1'b1; au_result = 8'h99; au_nzvc = 4'h8;
    @(negedge clk);
    au_done = 1'b0;
    checkOutput("ignore_spurious_done", {31'd0, rsp_valid}, 32'd0);
    lu_done = 1'b1; lu_result = 8'h3C; lu_nzvc = 4'b0001;
    @(negedge clk);
    lu_done = 1'b0;
    req_valid = 1'b1; req_op = 4'b0100; req_a = 8'h11; req_b = 8'h22;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_hold", {rsp_valid, rsp_result, rsp_nzvc, rsp_unit, rsp_err, req_ready, au_valid},
                  {1'b1, 8'h3C, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("bp_after_hs", {rsp_valid, req_ready, au_valid, lu_valid}, 32'b0100);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("bp_second_issue", {au_valid, au_op, au_a, au_b}, {1'b1, 3'd4, 8'h11, 8'h22});
    @(negedge clk);
    au_done = 1'b1; au_result = 8'h33; au_nzvc = 4'h0;
    @(negedge clk);
    au_done = 1'b0;
    checkOutput("bp_second_rsp", {rsp_valid, rsp_result, rsp_unit, rsp_err}, {1'b1, 8'h33, 1'b0, 1'b0});
    finishResp("bp");

    // Reset in WAIT abandons the transaction
    applyStimulus(4'b1001, 8'hAA, 8'h55);
    @(negedge clk);
    checkOutput("rst_pre_wait", {31'd0, lu_a == 8'hAA}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async", {req_ready, rsp_valid, lu_valid, lu_a, lu_op, rsp_result, rsp_err},
                {1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    lu_done = 1'b1; lu_result = 8'hFF; lu_nzvc = 4'hF;
    bad = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
    end
    lu_done = 1'b0;
    checkOutput("rst_late_done_ignored", bad, 0);
    applyStimulus(4'b0010, 8'h03, 8'h04);
    checkOutput("rst_next_issue", {au_valid, au_a, au_b}, {1'b1, 8'h03, 8'h04});
    @(negedge clk);
    au_done = 1'b1; au_result = 8'h07; au_nzvc = 4'h0;
    @(negedge clk);
    au_done = 1'b0;
    checkOutput("rst_next_rsp", {rsp_valid, rsp_result, rsp_err}, {1'b1, 8'h07, 1'b0});
    finishResp("rst_next");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
